apb_slave_mem: RTL and testbench

- APB slave register-file stage directly downstream of the APB master bridge.
- Consumes PSEL/PENABLE/PADDR/PWRITE/PWDATA from one of the bridge's two select lines (PSEL1 or PSEL2); PADDR[8] is already decoded upstream into the select.
- Returns PREADY, PRDATA and PSLVERR.
- Provides a byte-wide memory with a programmable number of wait states and out-of-range error reporting.
- Two instances are used, one per bridge select.

---
 rtl/apb_slave_mem.sv | 105 ++++++++++
 tb/tb_apb_slave_mem.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB slave register file: byte-wide memory behind one bridge select,
// with programmable wait states and out-of-range error response.
module apb_slave_mem #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L    = 4'(WAIT_CYCLES);
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [IDX_W-1:0]  addr_l;
    logic              write_l;
    logic [DATA_W-1:0] wdata_l;
    logic              err_l;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             setup;
    logic             access;
    logic             new_err;
    logic [IDX_W-1:0] new_idx;

    assign setup   = PSEL & ~PENABLE;
    assign access  = PSEL & PENABLE;
    assign new_err = ({1'b0, PADDR} >= DEPTH_L);
    assign new_idx = PADDR[IDX_W-1:0];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_l  <= '0;
            write_l <= 1'b0;
            wdata_l <= '0;
            err_l   <= 1'b0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // A setup cycle restarts the transfer from either state.
            unique case (1'b1)
                setup: begin
                    state   <= ACCESS;
                    addr_l  <= new_idx;
                    write_l <= PWRITE;
                    wdata_l <= PWDATA;
                    err_l   <= new_err;
                    cnt     <= WAIT_L;
                    PREADY  <= ZERO_WAIT;
                    PSLVERR <= ZERO_WAIT & new_err;
                    if (ZERO_WAIT) begin
                        PRDATA <= (!PWRITE && !new_err) ? mem[new_idx] : '0;
                    end
                end
                (state == ACCESS) && !PSEL: begin
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
                (state == ACCESS) && access && PREADY: begin
                    if (write_l && !err_l) begin
                        mem[addr_l] <= wdata_l;
                    end
                    state   <= IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
                (state == ACCESS) && access && !PREADY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        PREADY  <= 1'b1;
                        PSLVERR <= err_l;
                        PRDATA  <= (!write_l && !err_l) ? mem[addr_l] : '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized bench for apb_slave_mem: one 2-wait and one 0-wait
// instance checked against an array model of the memory.
module tb_apb_slave_mem;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       psel    [2];
    logic       penable [2];
    logic [7:0] paddr   [2];
    logic       pwrite  [2];
    logic [7:0] pwdata  [2];
    logic       pready  [2];
    logic [7:0] prdata  [2];
    logic       pslverr [2];

    int         wt [2] = '{2, 0};
    logic [7:0] mm [2][64];
    int         nvec = 0;
    int         nerr = 0;
    bit         rdone;

    always #5 PCLK = ~PCLK;

    apb_slave_mem #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2)
    ) u_dut_w2 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(psel[0]), .PENABLE(penable[0]),
        .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PWDATA(pwdata[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_mem #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(0)
    ) u_dut_w0 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(psel[1]), .PENABLE(penable[1]),
        .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PWDATA(pwdata[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++)
                mm[k][i] = 8'h00;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge PCLK);
            for (int k = 0; k < 2; k++) begin
                psel[k]    = 1'b0;
                penable[k] = 1'b0;
                chk("idle_rdy", pready[k], 0);
            end
        end
    endtask

    // One full transfer; pre=1 first opens a dummy write and restarts it.
    task automatic xfer(int k, bit wr, logic [7:0] a, logic [7:0] d,
                        bit pre = 1'b0);
        bit         done;
        bit         e;
        logic [7:0] expd;
        @(negedge PCLK);
        chk("start_rdy", pready[k], 0);
        chk("start_err", pslverr[k], 0);
        if (pre) begin
            psel[k]    = 1'b1;
            penable[k] = 1'b0;
            paddr[k]   = 8'($urandom_range(0, 63));
            pwrite[k]  = 1'b1;
            pwdata[k]  = 8'($urandom);
            @(negedge PCLK);
            penable[k] = 1'b1;
            @(negedge PCLK);
        end
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        paddr[k]   = a;
        pwrite[k]  = wr;
        pwdata[k]  = d;
        e    = (a >= 8'd64);
        expd = e ? 8'h00 : mm[k][a[5:0]];
        done = 1'b0;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge PCLK);
            penable[k] = 1'b1;
            paddr[k]   = 8'($urandom);
            pwrite[k]  = 1'($urandom);
            pwdata[k]  = 8'($urandom);
            if (pready[k]) begin
                done = 1'b1;
                chk("latency", c, wt[k]);
                chk("pslverr", pslverr[k], e);
                if (!wr) chk("prdata", prdata[k], expd);
            end else begin
                chk("err_wo_rdy", pslverr[k], 0);
            end
        end
        if (!done) chk("timeout", 0, 1);
        @(posedge PCLK);
        if (done && wr && !e) mm[k][a[5:0]] = d;
    endtask

    task automatic abort_w2(logic [7:0] a, logic [7:0] d);
        @(negedge PCLK);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        paddr[0]   = a;
        pwrite[0]  = 1'b1;
        pwdata[0]  = d;
        @(negedge PCLK);
        penable[0] = 1'b1;
        @(negedge PCLK);
        chk("abort_wait", pready[0], 0);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            chk("abort_rdy", pready[0], 0);
        end
    endtask

    task automatic proto_err(int k, logic [7:0] a);
        @(negedge PCLK);
        psel[k]    = 1'b1;
        penable[k] = 1'b1;
        paddr[k]   = a;
        pwrite[k]  = 1'b1;
        pwdata[k]  = 8'($urandom);
        repeat (5) begin
            @(negedge PCLK);
            chk("proto_rdy", pready[k], 0);
        end
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         wr;
        bit         pre;
        int         k;
        logic [7:0] a;
        for (int i = 0; i < 2; i++) begin
            psel[i]    = 1'b0;
            penable[i] = 1'b0;
            paddr[i]   = 8'h00;
            pwrite[i]  = 1'b0;
            pwdata[i]  = 8'h00;
        end
        clear_model();
        PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rdy", pready[i], 0);
            chk("rst_data", prdata[i], 0);
            chk("rst_err", pslverr[i], 0);
        end
        PRESETn = 1'b1;
        idle(2);

        xfer(0, 1'b1, 8'h10, 8'hA5);
        xfer(0, 1'b0, 8'h10, 8'h00);
        xfer(1, 1'b1, 8'h00, 8'h3C);
        xfer(1, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 2; i++) begin
            xfer(i, 1'b1, 8'h3F, 8'h5E);
            xfer(i, 1'b1, 8'h40, 8'h77);
            xfer(i, 1'b0, 8'h40, 8'h00);
            xfer(i, 1'b0, 8'h3F, 8'h00);
            xfer(i, 1'b0, 8'hFF, 8'h00);
        end
        xfer(0, 1'b1, 8'h20, 8'h42);
        abort_w2(8'h20, 8'h99);
        xfer(0, 1'b0, 8'h20, 8'h00);
        proto_err(0, 8'h10);
        xfer(0, 1'b0, 8'h10, 8'h00);
        proto_err(1, 8'h00);
        xfer(1, 1'b0, 8'h00, 8'h00);
        xfer(0, 1'b1, 8'h21, 8'hC3, 1'b1);
        xfer(0, 1'b0, 8'h21, 8'h00);

        repeat (300) begin
            k   = $urandom_range(0, 1);
            a   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255))
                                              : 8'($urandom_range(0, 63));
            wr  = 1'($urandom);
            pre = (k == 0) && ($urandom_range(0, 9) == 0);
            xfer(k, wr, a, 8'($urandom), pre);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        xfer(0, 1'b1, 8'h05, 8'h11);
        @(negedge PCLK);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        paddr[0]   = 8'h05;
        pwrite[0]  = 1'b0;
        rdone      = 1'b0;
        for (int c = 0; c < 16 && !rdone; c++) begin
            @(negedge PCLK);
            penable[0] = 1'b1;
            if (pready[0]) rdone = 1'b1;
        end
        chk("rst_pre_rdy", pready[0], 1);
        chk("rst_pre_data", prdata[0], 8'h11);
        PRESETn = 1'b0;
        #1;
        chk("rst_mid_rdy", pready[0], 0);
        chk("rst_mid_err", pslverr[0], 0);
        chk("rst_mid_data", prdata[0], 0);
        chk("rst_mid_data0", prdata[1], 0);
        clear_model();
        @(negedge PCLK);
        PRESETn = 1'b1;
        psel[0] = 1'b0;
        psel[1] = 1'b0;
        idle(1);
        xfer(0, 1'b0, 8'h05, 8'h00);
        xfer(1, 1'b0, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
